lif_sequencer: RTL and testbench

Byte-stream command sequencer in front of the LIF/PWM neuron datapath. It decodes a command stream into setup writes (weights, inputs, threshold, bias, shift, batchnorm) and timed execute bursts. It counts output spikes over each burst and reports the total, so a host can run whole inference steps without toggling pins cycle by cycle. The neuron wrapper gates its setup enable with cfg_we, so the datapath is written only on cycles this block selects.

---
 rtl/lif_sequencer.sv | 133 +++++++++++++
 tb/tb_lif_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_sequencer.sv
// lif_sequencer: byte-stream command sequencer for the LIF/PWM neuron.
// Decodes opcodes into setup strobes and timed execute bursts, counts spikes.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_data/valid/ready     command + payload byte stream
//   abort                   synchronous return to idle
//   cfg_we/sel/data         one-cycle setup write to the datapath
//   exec_en, spike_in       execute enable out, registered spike back
//   result_valid            one-cycle pulse, spike_count holds the burst total
//   busy                    high outside idle
module lif_sequencer #(
  parameter int N_STAGES   = 5,
  parameter int VEC_BYTES  = (2**N_STAGES)/8,
  parameter int COUNT_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  abort,
  output logic                  cfg_we,
  output logic [2:0]            cfg_sel,
  output logic [7:0]            cfg_data,
  output logic                  exec_en,
  input  logic                  spike_in,
  output logic                  result_valid,
  output logic [COUNT_BITS-1:0] spike_count,
  output logic                  busy
);

  localparam int REM_W = $clog2(VEC_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [2:0]       code;
  logic [REM_W-1:0] remaining;
  logic [5:0]       run_cnt;
  logic             exec_q;

  logic op_run;
  logic op_rsv;
  logic op_vec;

  assign op_run = in_data[2:0] == 3'b111;
  assign op_rsv = in_data[2:0] == 3'b101;
  assign op_vec = in_data[2:1] == 2'b00;

  assign in_ready = (state == S_IDLE || state == S_LOAD) && !abort;
  assign busy     = state != S_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      code         <= '0;
      remaining    <= '0;
      run_cnt      <= '0;
      exec_q       <= 1'b0;
      cfg_we       <= 1'b0;
      cfg_sel      <= '0;
      cfg_data     <= '0;
      exec_en      <= 1'b0;
      result_valid <= 1'b0;
      spike_count  <= '0;
    end else begin
      cfg_we       <= 1'b0;
      result_valid <= 1'b0;
      // exec_q lines up with the datapath's registered spike output
      exec_q       <= exec_en;
      if (exec_q && spike_in && spike_count != '1)
        spike_count <= spike_count + 1'b1;

      if (abort) begin
        state   <= S_IDLE;
        exec_en <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (in_valid) begin
              unique case (1'b1)
                op_run: begin
                  run_cnt     <= {1'b0, in_data[7:3]} + 6'd1;
                  spike_count <= '0;
                  exec_en     <= 1'b1;
                  state       <= S_RUN;
                end
                op_rsv: state <= S_IDLE;
                default: begin
                  code      <= in_data[2:0];
                  remaining <= op_vec ? REM_W'(VEC_BYTES)
                                      : REM_W'(1);
                  state     <= S_LOAD;
                end
              endcase
            end
          end
          S_LOAD: begin
            if (in_valid) begin
              cfg_we    <= 1'b1;
              cfg_sel   <= code;
              cfg_data  <= in_data;
              remaining <= remaining - 1'b1;
              if (remaining == REM_W'(1))
                state <= S_IDLE;
            end
          end
          S_RUN: begin
            if (run_cnt == 6'd1) begin
              exec_en <= 1'b0;
              state   <= S_DRAIN;
            end else begin
              run_cnt <= run_cnt - 6'd1;
            end
          end
          S_DRAIN: begin
            result_valid <= 1'b1;
            state        <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lif_sequencer.sv
// tb_lif_sequencer: directed bench with strobe/result scoreboards.
// Expected strobes and spike totals are queued at drive time.
module tb_lif_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic       cfg_we;
  logic [2:0] cfg_sel;
  logic [7:0] cfg_data;
  logic       exec_en;
  logic       spike_in;
  logic       result_valid;
  logic [5:0] spike_count;
  logic       busy;

  int passed;
  int failed;
  int total;
  int we_cnt;

  logic [10:0] exp_q[$];
  int          res_q[$];
  logic [10:0] mon_e;
  int          mon_r;

  lif_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .abort        (abort),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_data     (cfg_data),
    .exec_en      (exec_en),
    .spike_in     (spike_in),
    .result_valid (result_valid),
    .spike_count  (spike_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic payload(input logic [2:0] sel, input logic [7:0] b);
    exp_q.push_back({sel, b});
    send(b);
  endtask

  // toggle=1 flips spike_in every cycle of the burst
  task automatic run_burst(input logic [7:0] op, input bit toggle,
                           input int exp_len, input int exp_cnt);
    int n_exec;
    int last_exec;
    int rv_at;
    int bad_ready;
    n_exec    = 0;
    last_exec = -1;
    rv_at     = -1;
    bad_ready = 0;
    res_q.push_back(exp_cnt);
    send(op);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exec_en) begin
        n_exec++;
        last_exec = i;
      end
      if (busy && in_ready) bad_ready++;
      if (toggle) spike_in = ~spike_in;
      if (result_valid) begin
        rv_at = i;
        break;
      end
    end
    chk("result_seen", int'(rv_at >= 0), 1);
    chk("exec_len", n_exec, exp_len);
    chk("result_gap", rv_at - last_exec, 2);
    chk("ready_low_busy", bad_ready, 0);
    @(negedge clk);
    chk("idle_after_done", int'(busy), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && cfg_we) begin
      we_cnt++;
      chk("we_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("strobe_sel", int'(cfg_sel), int'(mon_e[10:8]));
        chk("strobe_data", int'(cfg_data), int'(mon_e[7:0]));
      end
      chk("we_excl_exec", int'(exec_en), 0);
    end
    if (rst_n && result_valid) begin
      chk("result_expected", int'(res_q.size() != 0), 1);
      if (res_q.size() != 0) begin
        mon_r = res_q.pop_front();
        chk("spike_count", int'(spike_count), mon_r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    passed   = 0;
    failed   = 0;
    total    = 0;
    we_cnt   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    abort    = 1'b0;
    spike_in = 1'b0;
    #1;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_we", int'(cfg_we), 0);
    chk("rst_exec", int'(exec_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(spike_count), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // weights vector, back-to-back payload
    send(8'h01);
    chk("load_busy", int'(busy), 1);
    payload(3'b001, 8'hAA);
    chk("we_b2b0", int'(cfg_we), 1);
    chk("ready_load", int'(in_ready), 1);
    payload(3'b001, 8'h55);
    chk("we_b2b1", int'(cfg_we), 1);
    payload(3'b001, 8'hF0);
    chk("we_b2b2", int'(cfg_we), 1);
    payload(3'b001, 8'h0F);
    chk("we_b2b3", int'(cfg_we), 1);
    chk("load_to_idle", int'(busy), 0);
    chk("ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // threshold with an in_valid gap
    w0 = we_cnt;
    send(8'h02);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("gap_no_we", int'(cfg_we), 0);
    end
    payload(3'b010, 8'h05);
    @(posedge clk);
    #1;
    chk("gap_one_strobe", we_cnt - w0, 1);

    // bursts
    spike_in = 1'b1;
    run_burst(8'h3F, 1'b0, 8, 8);
    spike_in = 1'b1;
    run_burst(8'hFF, 1'b1, 32, 16);
    spike_in = 1'b0;

    // reserved opcode, then shift
    w0 = we_cnt;
    send(8'h05);
    chk("rsv_idle", int'(busy), 0);
    chk("rsv_no_we", int'(cfg_we), 0);
    send(8'h04);
    payload(3'b100, 8'h03);
    @(posedge clk);
    #1;
    chk("shift_one_strobe", we_cnt - w0, 1);

    // abort in RUN cycle 3 of a 10-cycle burst
    spike_in = 1'b1;
    send(8'h4F);
    chk("abort_run1", int'(exec_en), 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    #1;
    chk("abort_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_exec", int'(exec_en), 0);
    chk("abort_idle", int'(busy), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_result", res_q.size(), 0);
    spike_in = 1'b0;

    // abort during LOAD, byte in abort cycle dropped
    w0 = we_cnt;
    send(8'h00);
    in_valid = 1'b1;
    in_data  = 8'h11;
    abort    = 1'b1;
    #1;
    chk("abort_load_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("abort_load_idle", int'(busy), 0);
    send(8'h03);
    payload(3'b011, 8'h22);
    @(posedge clk);
    #1;
    chk("abort_load_strobes", we_cnt - w0, 1);

    // reset after 2 of 4 weight bytes
    send(8'h01);
    payload(3'b001, 8'hA1);
    payload(3'b001, 8'hA2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", int'(cfg_we), 0);
    chk("mid_rst_sel", int'(cfg_sel), 0);
    chk("mid_rst_data", int'(cfg_data), 0);
    chk("mid_rst_count", int'(spike_count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h02);
    payload(3'b010, 8'h77);
    @(posedge clk);
    #1;

    // reset mid-RUN drops exec_en at once
    send(8'h07);
    chk("rrun_exec", int'(exec_en), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rrun_exec_drop", int'(exec_en), 0);
    #1 rst_n = 1'b1;

    repeat (3) @(negedge clk);
    chk("strobes_drained", exp_q.size(), 0);
    chk("results_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
